psum_bus_endpoint: RTL
======================

# psum_bus_endpoint

Bus-side endpoint of the PE-array psum network. It sits between the global buffer (GLB) and the shared psum bus that feeds the local-network switches. It transmits ipsum words from the GLB onto `ipsum_bus` and receives opsum words from `opsum_bus` back into the GLB. Each direction is buffered by its own FIFO, and a per-tile transfer count sequences the two directions and signals completion.

## Interface
Parameters:
- DATA_SIZE, 16, bits per psum lane
- IPSUM_NUM, 4, lanes per ipsum word
- OPSUM_NUM, 4, lanes per opsum word
- FIFO_DEPTH, 4, entries per direction FIFO; power of 2, ≥2

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- set_info  in  1  latch configuration
- cfg_num_psum  in  16  words to send and receive per tile
- start  in  1  begin tile
- busy  out  1  tile in progress
- done  out  1  one-cycle tile-complete pulse
- glb_ipsum_valid  in  1  GLB ipsum word valid
- glb_ipsum_data  in  IPSUM_NUM*DATA_SIZE  GLB ipsum word
- glb_ipsum_ready  out  1  endpoint accepts ipsum word
- ipsum_bus  out  IPSUM_NUM*DATA_SIZE+1  MSB is enable, low bits are lanes
- ipsum_ready_bus  in  1  bus consumer ready
- opsum_bus  in  OPSUM_NUM*DATA_SIZE+1  MSB is enable, low bits are lanes
- opsum_ready_bus  out  1  endpoint accepts opsum word
- glb_opsum_valid  out  1  opsum word to GLB valid
- glb_opsum_data  out  OPSUM_NUM*DATA_SIZE  opsum word to GLB
- glb_opsum_ready  in  1  GLB accepts opsum word

## Operation
Handshake rules:
- A transfer occurs on any interface in a cycle where valid/enable=1 and ready=1.
- A sender holds valid/enable and data stable until the transfer.

Configuration:
- `cfg_reg` latches `cfg_num_psum` when set_info=1 and the FSM is in IDLE.
- set_info is ignored in every other state.

Counters: `in_cnt` (GLB ipsum accepted) and `rx_cnt` (bus opsum accepted), each 16 bits, cleared on start.

FSM states: IDLE, RUN, DONE.
- IDLE: busy=0.
  - start=1 with cfg_reg≠0: go to RUN.
  - start=1 with cfg_reg=0: go to DONE directly.
- RUN: busy=1.
  - Go to DONE when rx_cnt==cfg_reg, in_cnt==cfg_reg, both FIFOs are empty, and no transfer is in flight.
  - start is ignored.
- DONE: done=1 and busy=0 for one cycle, then unconditionally return to IDLE.

TX path (GLB to bus):
- glb_ipsum_ready = RUN && !tx_full && in_cnt<cfg_reg.
  - Readiness ignores a same-cycle pop, so a push into a full FIFO is never allowed.
- ipsum_bus enable = !tx_empty.
- Lanes carry the FIFO head when enable=1. The whole bus is 0 when the FIFO is empty.
- A pop occurs on enable && ipsum_ready_bus.

RX path (bus to GLB):
- opsum_ready_bus = RUN && !rx_full && rx_cnt<cfg_reg.
- opsum_bus words offered outside this window are not accepted and stay pending on the bus.
- glb_opsum_valid = !rx_empty, and glb_opsum_data = FIFO head.
- glb_opsum_data is 0 when the FIFO is empty.

FIFO behaviour:
- Each FIFO has registered read/write pointers that are log2(FIFO_DEPTH)+1 bits wide. The extra MSB distinguishes full from empty on wrap-around.
- A simultaneous push and pop on a non-empty, non-full FIFO keeps the occupancy unchanged.

Reset (rst=0 at a clk edge):
- FSM goes to IDLE; cfg_reg, counters and pointers are cleared to 0.
- All outputs are 0: busy, done, glb_ipsum_ready, ipsum_bus, opsum_ready_bus, glb_opsum_valid, glb_opsum_data.
- A reset mid-tile discards FIFO contents, and no done pulse is produced.

## Timing
- All state is updated on the clk rising edge. Outputs are combinational from registered state only; there are no input-to-output combinational paths.
- TX latency: a GLB transfer at cycle t makes ipsum_bus enable=1 with that word at t+1, if the FIFO was empty.
- RX latency: a bus opsum transfer at cycle t makes glb_opsum_valid=1 at t+1, if the FIFO was empty.
- Throughput is one word per cycle per direction with continuous ready.
- Start response: start at cycle t raises busy=1 at t+1, and glb_ipsum_ready can be 1 at t+1.
- Completion: the last GLB opsum transfer at cycle t puts the FSM in DONE at t+1, with done=1 for that cycle only, and IDLE at t+2.
- start applied while in DONE is ignored. The next tile needs start in IDLE.

## Test plan
- Reset: hold rst=0 for 2 cycles with random inputs → all outputs 0. After release, busy=0 and done=0.
- Basic tile: cfg_num_psum=3, all readies 1. Send ipsum words 0x0001..0x0003 (lane 0) and loop them back as opsum → ipsum_bus shows 0x1_0000_0000_0000_0001.. in order, one cycle after each GLB transfer. glb_opsum_data matches. done pulses once, one cycle after the 3rd GLB opsum transfer.
- TX backpressure: FIFO_DEPTH=4, ipsum_ready_bus=0, GLB valid held → exactly 4 words are accepted, then glb_ipsum_ready=0. Raising ready drains the words in order with no loss or duplication.
- Count limit: cfg=2, GLB offers 5 words → glb_ipsum_ready drops after 2 accepts. opsum_ready_bus drops after 2 bus opsums, and a 3rd offered opsum stays pending.
- Zero count and ignored inputs: cfg=0, start → done at the next cycle, and no transfers occur. A set_info during RUN does not change cfg_reg. A start during RUN is ignored.
- Reset mid-tile: cfg=8, assert rst=0 after 3 transfers → FIFOs are empty and busy=0. No done pulse occurs. A fresh cfg=1 tile then completes normally.

Source files
------------

// File: rtl/psum_bus_endpoint_if.sv
// psum_bus_endpoint_if: bundles the GLB-side and psum-bus-side handshakes of the psum bus endpoint.
//   glb_ipsum_valid/data/ready : ipsum words from the GLB into the endpoint
//   ipsum_bus, ipsum_ready_bus : ipsum words onto the shared bus (MSB = enable)
//   opsum_bus, opsum_ready_bus : opsum words from the shared bus (MSB = enable)
//   glb_opsum_valid/data/ready : opsum words from the endpoint back to the GLB
//   slave modport = endpoint side, master modport = environment side
interface psum_bus_endpoint_if #(
    parameter int DATA_SIZE = 16,
    parameter int IPSUM_NUM = 4,
    parameter int OPSUM_NUM = 4
);
    logic                              glb_ipsum_valid;
    logic [IPSUM_NUM*DATA_SIZE-1:0]    glb_ipsum_data;
    logic                              glb_ipsum_ready;
    logic [IPSUM_NUM*DATA_SIZE:0]      ipsum_bus;
    logic                              ipsum_ready_bus;
    logic [OPSUM_NUM*DATA_SIZE:0]      opsum_bus;
    logic                              opsum_ready_bus;
    logic                              glb_opsum_valid;
    logic [OPSUM_NUM*DATA_SIZE-1:0]    glb_opsum_data;
    logic                              glb_opsum_ready;

    modport slave (
        input  glb_ipsum_valid, glb_ipsum_data, ipsum_ready_bus, opsum_bus, glb_opsum_ready,
        output glb_ipsum_ready, ipsum_bus, opsum_ready_bus, glb_opsum_valid, glb_opsum_data
    );

    modport master (
        output glb_ipsum_valid, glb_ipsum_data, ipsum_ready_bus, opsum_bus, glb_opsum_ready,
        input  glb_ipsum_ready, ipsum_bus, opsum_ready_bus, glb_opsum_valid, glb_opsum_data
    );
endinterface

// File: rtl/psum_bus_endpoint.sv
// psum_bus_endpoint: bus-side endpoint of the psum network, GLB ipsum -> ipsum_bus and opsum_bus -> GLB, per-tile counted.
//   clk          : clock
//   rst          : synchronous active-low reset
//   set_info     : latch cfg_num_psum into cfg_reg (IDLE only)
//   cfg_num_psum : words to send and receive per tile
//   start        : begin tile (IDLE only)
//   busy         : tile in progress
//   done         : one-cycle tile-complete pulse
//   bus          : handshake bundle (slave side), see psum_bus_endpoint_if
module psum_bus_endpoint #(
    parameter int DATA_SIZE  = 16,
    parameter int IPSUM_NUM  = 4,
    parameter int OPSUM_NUM  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      set_info,
    input  logic [15:0]               cfg_num_psum,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    psum_bus_endpoint_if.slave        bus
);
    localparam int IW = IPSUM_NUM * DATA_SIZE;
    localparam int OW = OPSUM_NUM * DATA_SIZE;
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [15:0]   cfg_reg;
    logic [15:0]   in_cnt;
    logic [15:0]   rx_cnt;
    logic [IW-1:0] tx_mem [FIFO_DEPTH];
    logic [OW-1:0] rx_mem [FIFO_DEPTH];
    logic [AW:0]   tx_wp;
    logic [AW:0]   tx_rp;
    logic [AW:0]   rx_wp;
    logic [AW:0]   rx_rp;
    logic [AW:0]   tx_lvl;
    logic [AW:0]   rx_lvl;
    logic          run;
    logic          tx_empty;
    logic          tx_full;
    logic          rx_empty;
    logic          rx_full;
    logic          tx_push;
    logic          tx_pop;
    logic          rx_push;
    logic          rx_pop;
    logic          tx_drain;
    logic          rx_drain;
    logic          finish;

    assign run      = state == RUN;
    assign tx_lvl   = tx_wp - tx_rp;
    assign rx_lvl   = rx_wp - rx_rp;
    assign tx_empty = tx_lvl == '0;
    assign rx_empty = rx_lvl == '0;
    // occupancy equal to depth only when the wrap bits differ and the index bits match
    assign tx_full  = tx_lvl == (AW+1)'(FIFO_DEPTH);
    assign rx_full  = rx_lvl == (AW+1)'(FIFO_DEPTH);

    assign bus.glb_ipsum_ready = run && !tx_full && in_cnt < cfg_reg;
    assign bus.ipsum_bus       = tx_empty ? '0 : {1'b1, tx_mem[tx_rp[AW-1:0]]};
    assign bus.opsum_ready_bus = run && !rx_full && rx_cnt < cfg_reg;
    assign bus.glb_opsum_valid = !rx_empty;
    assign bus.glb_opsum_data  = rx_empty ? '0 : rx_mem[rx_rp[AW-1:0]];

    assign tx_push = bus.glb_ipsum_valid && bus.glb_ipsum_ready;
    assign tx_pop  = !tx_empty && bus.ipsum_ready_bus;
    assign rx_push = bus.opsum_bus[OW] && bus.opsum_ready_bus;
    assign rx_pop  = !rx_empty && bus.glb_opsum_ready;

    // A FIFO counts as drained if it is empty or its last word leaves this cycle;
    // with both counts at cfg_reg no further push can arrive, so the tile ends
    // the cycle right after the final word is handed on.
    assign tx_drain = tx_empty || (tx_lvl == (AW+1)'(1) && tx_pop);
    assign rx_drain = rx_empty || (rx_lvl == (AW+1)'(1) && rx_pop);
    assign finish   = in_cnt == cfg_reg && rx_cnt == cfg_reg && tx_drain && rx_drain;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp[AW-1:0]] <= bus.glb_ipsum_data;
        if (rx_push) rx_mem[rx_wp[AW-1:0]] <= bus.opsum_bus[OW-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_wp <= '0;
            tx_rp <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
        end else begin
            tx_wp <= tx_wp + (AW+1)'(tx_push);
            tx_rp <= tx_rp + (AW+1)'(tx_pop);
            rx_wp <= rx_wp + (AW+1)'(rx_push);
            rx_rp <= rx_rp + (AW+1)'(rx_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            cfg_reg <= '0;
            in_cnt  <= '0;
            rx_cnt  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            in_cnt <= in_cnt + 16'(tx_push);
            rx_cnt <= rx_cnt + 16'(rx_push);
            case (state)
                IDLE: begin
                    if (set_info) cfg_reg <= cfg_num_psum;
                    if (start) begin
                        in_cnt <= '0;
                        rx_cnt <= '0;
                        state  <= cfg_reg != '0 ? RUN : DONE;
                        busy   <= cfg_reg != '0;
                        done   <= cfg_reg == '0;
                    end
                end
                RUN: begin
                    if (finish) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule
